// File: rtl/latch_id_ex_pkg.sv
// Shared definitions for the ID/EX stage: control-bit positions, drain FSM states
// and the opcode values the control decoder also uses.
package latch_id_ex_pkg;

    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_ALUOP_LO = 7;
    localparam int CTRL_ALUOP_HI = 8;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

endpackage

// File: rtl/latch_id_ex_hazard.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module hazard_load_use #(
    parameter int N_BITS_REG = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [N_BITS_REG-1:0] ex_rt,
    input  logic [N_BITS_REG-1:0] id_rs,
    input  logic [N_BITS_REG-1:0] id_rt,
    input  logic                  id_valid,
    input  logic                  run,
    output logic                  stall
);

    logic load_use;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) &
                      ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign stall    = load_use & id_valid & run;

endmodule

// File: rtl/latch_id_ex.sv
// ID/EX pipeline register with load-use stall and halt-drain FSM.
// Define ID_EX_STATS_EN to add the o_bubble_count flush/stall bubble counter.
module latch_id_ex
    import latch_id_ex_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_BITS_REG = 5,
    parameter int N_DRAIN    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic                  i_halt,
    input  logic                  i_flush,
    input  logic [N_BITS-1:0]     i_instruccion,
    input  logic [N_BITS-1:0]     i_pc4,
    input  logic [N_BITS-1:0]     i_rs_data,
    input  logic [N_BITS-1:0]     i_rt_data,
    input  logic [CTRL_W-1:0]     i_ctrl,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic [N_BITS-1:0]     o_pc4,
    output logic [N_BITS-1:0]     o_rs_data,
    output logic [N_BITS-1:0]     o_rt_data,
    output logic [N_BITS-1:0]     o_imm,
    output logic [N_BITS_REG-1:0] o_rs,
    output logic [N_BITS_REG-1:0] o_rt,
    output logic [N_BITS_REG-1:0] o_rd,
    output logic [5:0]            o_funct,
    output logic                  o_valid,
    output logic                  o_stall,
    output logic                  o_halted
`ifdef ID_EX_STATS_EN
    ,
    output logic [15:0]           o_bubble_count
`endif
);

    localparam int CNT_W = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  stall;
    logic                  bubble;
    logic                  capture_valid;
    logic [N_BITS_REG-1:0] id_rs, id_rt, id_rd;
    logic [N_BITS-1:0]     imm_ext;
    logic                  unused_opcode;

    assign id_rs         = i_instruccion[21 +: N_BITS_REG];
    assign id_rt         = i_instruccion[16 +: N_BITS_REG];
    assign id_rd         = i_instruccion[11 +: N_BITS_REG];
    assign imm_ext       = {{(N_BITS-16){i_instruccion[15]}}, i_instruccion[15:0]};
    assign unused_opcode = ^i_instruccion[N_BITS-1:26];

    hazard_load_use #(.N_BITS_REG(N_BITS_REG)) u_hazard (
        .ex_valid    (o_valid),
        .ex_mem_read (o_ctrl[CTRL_MEMREAD]),
        .ex_rt       (o_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_valid    (i_valid),
        .run         (state_q == ST_RUN),
        .stall       (stall)
    );

    assign o_stall       = stall;
    assign o_halted      = (state_q == ST_HALTED);
    assign bubble        = i_flush | stall | (state_q != ST_RUN);
    assign capture_valid = i_valid & ~i_halt;

    // A halt only counts if it actually enters EX: a flush or stall in the same cycle cancels it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (i_halt && i_valid && !i_flush && !stall) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(N_DRAIN - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_HALTED;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else if (i_enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_ctrl    <= '0;
            o_valid   <= 1'b0;
            o_pc4     <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_funct   <= '0;
        end else if (i_enable) begin
            if (bubble) begin
                o_ctrl    <= '0;
                o_valid   <= 1'b0;
                o_pc4     <= '0;
                o_rs_data <= '0;
                o_rt_data <= '0;
                o_imm     <= '0;
                o_rs      <= '0;
                o_rt      <= '0;
                o_rd      <= '0;
                o_funct   <= '0;
            end else begin
                o_ctrl    <= capture_valid ? i_ctrl : '0;
                o_valid   <= capture_valid;
                o_pc4     <= i_pc4;
                o_rs_data <= i_rs_data;
                o_rt_data <= i_rt_data;
                o_imm     <= imm_ext;
                o_rs      <= id_rs;
                o_rt      <= id_rt;
                o_rd      <= id_rd;
                o_funct   <= i_instruccion[5:0];
            end
        end
    end

`ifdef ID_EX_STATS_EN
    logic [15:0] bubble_count;

    // Only flush and load-use bubbles are counted; drain bubbles are expected behaviour
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bubble_count <= '0;
        end else if (i_enable && (i_flush || stall) && bubble_count != 16'hFFFF) begin
            bubble_count <= bubble_count + 16'd1;
        end
    end

    assign o_bubble_count = bubble_count;
`endif

endmodule
